// File: rtl/cpu54_pkg.sv
// cpu54_pkg: exception codes, CP0 Status bit positions and arbiter FSM states
package cpu54_pkg;
  localparam logic [7:0] EXC_INT  = 8'h00;
  localparam logic [7:0] EXC_SYS  = 8'h08;
  localparam logic [7:0] EXC_BRK  = 8'h09;
  localparam logic [7:0] EXC_RI   = 8'h0a;
  localparam logic [7:0] EXC_OV   = 8'h0c;
  localparam logic [7:0] EXC_TR   = 8'h0d;
  localparam logic [7:0] EXC_ERET = 8'h20;
  localparam logic [7:0] EXC_NONE = 8'hff;
  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LSB = 10;
  typedef enum logic {S_IDLE, S_FLUSH} state_e;
endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: 2-flop synchronizer plus one-cycle rising-edge pulse for one async line
module int_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic [2:0] sh_q, sh_d;
  // shift chain: [0] first sync flop, [1] second sync flop, [2] edge history
  always_comb sh_d = {sh_q[1:0], async_in};
  // history and synchronizer clear on reset
  always_ff @(posedge clk) sh_q <= rst ? '0 : sh_d;
  assign rise = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/exc_arbiter.sv
// exc_arbiter: prioritises exceptions/interrupts into one CP0 code, PC redirect and flush (EXT_INT_EN adds external lines)
module exc_arbiter
  import cpu54_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter int          NUM_EXT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        pc,
  input  logic               rsvd_instr,
  input  logic               ovf,
  input  logic               trap,
  input  logic               syscall,
  input  logic               brk,
  input  logic               eret,
  input  logic               timer_int,
  input  logic [NUM_EXT-1:0] ext_int,
  input  logic [31:0]        status,
  input  logic [31:0]        epc,
  output logic [7:0]         exc_type,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               flush,
  output logic [NUM_EXT:0]   int_pending
);
  state_e state_q, state_d;
  logic [NUM_EXT-1:0] ext_pend_q, ext_pend_d, ext_rise, ack_cand, ack_mask;
  logic irq, take, unused_ok;
`ifdef EXT_INT_EN
  for (genvar i = 0; i < NUM_EXT; i++) begin : g_sync
    int_sync_edge u_sync (.clk(clk), .rst(rst), .async_in(ext_int[i]), .rise(ext_rise[i]));
  end
  assign unused_ok = ^{pc, status};
`else
  assign ext_rise  = '0;
  assign unused_ok = ^{pc, status, ext_int};
`endif
  assign int_pending = {ext_pend_q, timer_int};
  assign irq = status[ST_IE] & ~status[ST_EXL] & |(int_pending & status[ST_IM_LSB +: NUM_EXT+1]);
  // fixed-priority select; only an idle, valid, non-reset cycle may issue a code
  always_comb begin
    take = ~rst & (state_q == S_IDLE) & instr_valid;
    exc_type = ~take     ? EXC_NONE :
               rsvd_instr ? EXC_RI   :
               ovf        ? EXC_OV   :
               trap       ? EXC_TR   :
               syscall    ? EXC_SYS  :
               brk        ? EXC_BRK  :
               eret       ? EXC_ERET :
               irq        ? EXC_INT  : EXC_NONE;
  end
  assign redirect    = exc_type != EXC_NONE;
  assign redirect_pc = (exc_type == EXC_ERET) ? epc : EXC_VECTOR;
  assign flush       = state_q == S_FLUSH;
  // acknowledge clears the lowest enabled pending line; a same-cycle new edge wins
  always_comb begin
    ack_cand   = ext_pend_q & status[ST_IM_LSB+1 +: NUM_EXT];
    ack_mask   = (exc_type == EXC_INT) ? ack_cand & (~ack_cand + 1'b1) : '0;
    ext_pend_d = (ext_pend_q & ~ack_mask) | ext_rise;
    state_d    = redirect ? S_FLUSH : S_IDLE;
  end
  // FSM and pending bits; FLUSH always lasts exactly one cycle
  always_ff @(posedge clk) begin
    state_q    <= rst ? S_IDLE : state_d;
    ext_pend_q <= rst ? '0 : ext_pend_d;
  end
endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: vector table plus hand sequences for exc_arbiter
module tb_exc_arbiter;
  import cpu54_pkg::*;
  localparam int          NUM_EXT = 4;
  localparam logic [31:0] VEC     = 32'h00400004;
  logic clk = 1'b0;
  logic rst, instr_valid, rsvd_instr, ovf, trap, syscall, brk, eret, timer_int;
  logic [31:0] pc, status, epc, redirect_pc;
  logic [NUM_EXT-1:0] ext_int;
  logic [7:0] exc_type;
  logic redirect, flush;
  logic [NUM_EXT:0] int_pending;
  always #5 clk = ~clk;
  exc_arbiter #(.EXC_VECTOR(VEC), .NUM_EXT(NUM_EXT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
    .rsvd_instr(rsvd_instr), .ovf(ovf), .trap(trap), .syscall(syscall),
    .brk(brk), .eret(eret), .timer_int(timer_int), .ext_int(ext_int),
    .status(status), .epc(epc), .exc_type(exc_type), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .int_pending(int_pending)
  );
  typedef struct packed {
    logic        v;
    logic [5:0]  fl;
    logic        tmr;
    logic [31:0] st;
    logic [31:0] epc;
    logic [7:0]  et;
    logic [31:0] rpc;
  } vec_t;
  typedef struct packed {
    logic [7:0]  et;
    logic        rd;
    logic [31:0] rpc;
    logic        fl;
  } exp_t;
  vec_t vecs[16];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask
  task automatic set_flags(input logic v, input logic [5:0] f, input logic t);
    instr_valid = v;
    {rsvd_instr, ovf, trap, syscall, brk, eret} = f;
    timer_int = t;
  endtask
  task automatic check_exp(input string nm);
    exp_t e;
    e = sb.pop_front();
    chk({nm, " exc_type"}, {24'h0, exc_type}, {24'h0, e.et});
    chk({nm, " redirect"}, {31'h0, redirect}, {31'h0, e.rd});
    chk({nm, " flush"}, {31'h0, flush}, {31'h0, e.fl});
    if (e.rd) chk({nm, " redirect_pc"}, redirect_pc, e.rpc);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    exp_t e;
    vecs[0]  = '{1'b1, 6'b110000, 1'b0, 32'h401, 32'h00400200, 8'h0a, VEC};
    vecs[1]  = '{1'b1, 6'b011000, 1'b0, 32'h401, 32'h00400200, 8'h0c, VEC};
    vecs[2]  = '{1'b1, 6'b001100, 1'b0, 32'h401, 32'h00400200, 8'h0d, VEC};
    vecs[3]  = '{1'b1, 6'b000110, 1'b0, 32'h401, 32'h00400200, 8'h08, VEC};
    vecs[4]  = '{1'b1, 6'b000011, 1'b0, 32'h401, 32'h00400200, 8'h09, VEC};
    vecs[5]  = '{1'b1, 6'b000001, 1'b0, 32'h401, 32'h00400200, 8'h20, 32'h00400200};
    vecs[6]  = '{1'b1, 6'b000000, 1'b1, 32'h401, 32'h00400200, 8'h00, VEC};
    vecs[7]  = '{1'b1, 6'b000000, 1'b1, 32'h403, 32'h00400200, 8'hff, VEC};
    vecs[8]  = '{1'b1, 6'b000000, 1'b1, 32'h400, 32'h00400200, 8'hff, VEC};
    vecs[9]  = '{1'b1, 6'b000000, 1'b1, 32'h001, 32'h00400200, 8'hff, VEC};
    vecs[10] = '{1'b1, 6'b000001, 1'b1, 32'h401, 32'h00400200, 8'h20, 32'h00400200};
    vecs[11] = '{1'b1, 6'b000000, 1'b0, 32'h401, 32'h00400200, 8'hff, VEC};
    vecs[12] = '{1'b1, 6'b000100, 1'b0, 32'h403, 32'h00400200, 8'h08, VEC};
    vecs[13] = '{1'b0, 6'b110001, 1'b1, 32'h401, 32'h00400200, 8'hff, VEC};
    vecs[14] = '{1'b1, 6'b100001, 1'b1, 32'h401, 32'h00400200, 8'h0a, VEC};
    vecs[15] = '{1'b1, 6'b000001, 1'b0, 32'h401, 32'h12345678, 8'h20, 32'h12345678};
    rst = 1'b1;
    set_flags(1'b0, 6'b0, 1'b0);
    pc = 32'h0;
    status = 32'h0;
    epc = 32'h0;
    ext_int = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset exc_type", {24'h0, exc_type}, 32'hff);
    chk("reset redirect", {31'h0, redirect}, 32'h0);
    chk("reset redirect_pc", redirect_pc, VEC);
    chk("reset flush", {31'h0, flush}, 32'h0);
    chk("reset int_pending", {27'h0, int_pending}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_flags(vecs[i].v, vecs[i].fl, vecs[i].tmr);
      status = vecs[i].st;
      epc = vecs[i].epc;
      pc = 32'h00400100 + 32'(i * 4);
      e = '{vecs[i].et, vecs[i].et != EXC_NONE, vecs[i].rpc, 1'b0};
      sb.push_back(e);
      e = '{EXC_NONE, 1'b0, VEC, vecs[i].et != EXC_NONE};
      sb.push_back(e);
      #1;
      check_exp($sformatf("v%0d", i));
      @(negedge clk);
      set_flags(1'b0, 6'b0, 1'b0);
      #1;
      check_exp($sformatf("v%0d next", i));
    end
    status = 32'h401;
    @(negedge clk);
    set_flags(1'b1, 6'b000100, 1'b0);
    #1;
    chk("b2b first", {24'h0, exc_type}, 32'h08);
    @(negedge clk);
    #1;
    chk("b2b dropped exc_type", {24'h0, exc_type}, 32'hff);
    chk("b2b dropped redirect", {31'h0, redirect}, 32'h0);
    chk("b2b flush", {31'h0, flush}, 32'h1);
    @(negedge clk);
    #1;
    chk("b2b second", {24'h0, exc_type}, 32'h08);
    @(negedge clk);
    set_flags(1'b0, 6'b0, 1'b0);
    @(negedge clk);
    set_flags(1'b1, 6'b000010, 1'b0);
    #1;
    chk("rstflush issue", {24'h0, exc_type}, 32'h09);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstflush in flush", {31'h0, flush}, 32'h1);
    @(negedge clk);
    #1;
    chk("rst idle flush", {31'h0, flush}, 32'h0);
    chk("rst overrides flags", {24'h0, exc_type}, 32'hff);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst int_pending", {27'h0, int_pending}, 32'h0);
    chk("post rst idle issue", {24'h0, exc_type}, 32'h09);
    @(negedge clk);
    set_flags(1'b0, 6'b0, 1'b0);
    @(negedge clk);
`ifdef EXT_INT_EN
    status = 32'h00002001;
    ext_int[2] = 1'b1;
    @(negedge clk);
    ext_int[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("ext not yet", {31'h0, int_pending[3]}, 32'h0);
    @(negedge clk);
    #1;
    chk("ext after 3", {27'h0, int_pending}, 32'h8);
    instr_valid = 1'b1;
    #1;
    chk("ext int taken", {24'h0, exc_type}, 32'h00);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("ext ack clears", {27'h0, int_pending}, 32'h0);
    @(negedge clk);
    ext_int[2] = 1'b1;
    @(negedge clk);
    ext_int[2] = 1'b0;
    @(negedge clk);
    ext_int[2] = 1'b1;
    @(negedge clk);
    ext_int[2] = 1'b0;
    #1;
    chk("ext pend before ack", {31'h0, int_pending[3]}, 32'h1);
    @(negedge clk);
    instr_valid = 1'b1;
    #1;
    chk("ext ack with edge", {24'h0, exc_type}, 32'h00);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("set wins over ack", {27'h0, int_pending}, 32'h8);
    @(negedge clk);
    instr_valid = 1'b1;
    #1;
    chk("ext retaken", {24'h0, exc_type}, 32'h00);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("ext final clear", {27'h0, int_pending}, 32'h0);
`else
    status = 32'h00007c01;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ext_int = k[0] ? 4'hf : 4'h0;
      instr_valid = 1'b1;
      #1;
      chk($sformatf("noext pending %0d", k), {27'h0, int_pending}, 32'h0);
      chk($sformatf("noext exc %0d", k), {24'h0, exc_type}, 32'hff);
    end
`endif
    @(negedge clk);
    set_flags(1'b0, 6'b0, 1'b0);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
